// File: rtl/grid_pkg.sv
// Shared state encoding, default widths and arithmetic helpers for the grid accumulator.
// Helpers operate at MAX_W bits; callers zero-extend inputs and slice results to ACC_WIDTH.
package grid_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_ACC_WIDTH  = 40;
   localparam int unsigned DEF_ADDR_WIDTH = 8;
   localparam int unsigned MAX_W          = 64;

   typedef enum logic [1:0] {
      StClear,
      StAccum,
      StDrain,
      StDump
   } grid_state_e;

   typedef struct packed {
      logic             sat;
      logic [MAX_W-1:0] val;
   } sat_res_t;

   // Replicates bit (width-1) of val into every bit above it.
   function automatic logic [MAX_W-1:0] sign_extend(input logic [MAX_W-1:0] val,
                                                    input int unsigned     width);
      logic [MAX_W-1:0]         res;
      logic [$clog2(MAX_W)-1:0] msb;
      msb = $clog2(MAX_W)'(width - 1);
      for (int i = 0; i < int'(MAX_W); i++) begin
         res[i] = (i < int'(width)) ? val[i] : val[msb];
      end
      return res;
   endfunction

   // a and b are sign-extended width-bit values, so their MAX_W-bit sum is exact.
   function automatic sat_res_t sat_add(input logic [MAX_W-1:0] a,
                                        input logic [MAX_W-1:0] b,
                                        input int unsigned     width);
      sat_res_t                res;
      logic signed [MAX_W-1:0] sum;
      logic signed [MAX_W-1:0] hi;
      logic signed [MAX_W-1:0] lo;
      sum     = $signed(a + b);
      hi      = $signed((MAX_W'(1) << (width - 1)) - MAX_W'(1));
      lo      = ~hi;
      res.sat = (sum > hi) || (sum < lo);
      if (sum > hi) begin
         res.val = hi;
      end else if (sum < lo) begin
         res.val = lo;
      end else begin
         res.val = sum;
      end
      return res;
   endfunction

endpackage

// File: rtl/grid_acc_ram.sv
// Simple dual-port grid RAM: one write port, one synchronous read port with 1-cycle latency.
// A read and write to the same address on the same edge returns the old contents.
module grid_acc_ram #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned ACC_WIDTH  = 40
) (
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [ACC_WIDTH-1:0]  i_wdata,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [ACC_WIDTH-1:0]  o_rdata
);

   logic [ACC_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/grid_accumulator.sv
// Accumulates a signed (address, sample) stream into a grid RAM by read-modify-write, with a
// post-reset clear sweep and a clear-on-read dump. Define GRID_ACC_SAT_EN for saturating sums.
module grid_accumulator
   import grid_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_ce,
   input  logic [ADDR_WIDTH-1:0] i_in_addr,
   input  logic [DATA_WIDTH-1:0] i_in_data,
   input  logic                  i_dump_req,
   output logic                  o_busy,
   output logic                  o_out_valid,
   output logic [ADDR_WIDTH-1:0] o_out_addr,
   output logic [ACC_WIDTH-1:0]  o_out_data,
   output logic                  o_dump_done
`ifdef GRID_ACC_SAT_EN
   ,
   output logic                  o_sat_flag
`endif
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   grid_state_e           r_state;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic                  r_issued;
   logic                  r_s1_valid;
   logic [ADDR_WIDTH-1:0] r_s1_addr;
   logic [DATA_WIDTH-1:0] r_s1_data;
   logic                  r_wr_valid;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [ACC_WIDTH-1:0]  r_wr_data;
   logic                  r_rd_valid;
   logic [ADDR_WIDTH-1:0] r_rd_addr;

   logic                  w_accept;
   logic                  w_dump_rd;
   logic                  w_sweep;
   logic                  w_dump_start;
   logic                  w_fwd;
   logic                  w_we;
   logic [ADDR_WIDTH-1:0] w_waddr;
   logic [ADDR_WIDTH-1:0] w_raddr;
   logic [ACC_WIDTH-1:0]  w_wdata;
   logic [ACC_WIDTH-1:0]  w_rd_data;
   logic [ACC_WIDTH-1:0]  w_operand;
   logic [ACC_WIDTH-1:0]  w_sum;
   logic [MAX_W-1:0]      w_data_ext;

   assign w_accept     = i_ce && (r_state == StAccum);
   assign w_dump_rd    = (r_state == StDump) && !r_issued;
   assign w_sweep      = (r_state == StClear) || w_dump_rd;
   assign w_dump_start = (r_state == StDrain) && !r_s1_valid && !r_wr_valid;
   // The RAM returns stale data when S1 reads the cell being written on the same edge.
   assign w_fwd        = r_wr_valid && (r_wr_addr == r_s1_addr);
   assign w_operand    = w_fwd ? r_wr_data : w_rd_data;
   assign w_data_ext   = sign_extend(MAX_W'(r_s1_data), DATA_WIDTH);

`ifdef GRID_ACC_SAT_EN
   sat_res_t         w_res;
   logic [MAX_W-1:0] w_op_ext;
   logic             w_unused_hi;

   assign w_op_ext    = sign_extend(MAX_W'(w_operand), ACC_WIDTH);
   assign w_res       = sat_add(w_op_ext, w_data_ext, ACC_WIDTH);
   assign w_sum       = w_res.val[ACC_WIDTH-1:0];
   assign w_unused_hi = ^w_res.val[MAX_W-1:ACC_WIDTH];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_sat_flag <= 1'b0;
      end else if (w_dump_start) begin
         o_sat_flag <= 1'b0;
      end else if (r_s1_valid && w_res.sat) begin
         o_sat_flag <= 1'b1;
      end
   end
`else
   logic w_unused_hi;

   assign w_sum       = w_operand + w_data_ext[ACC_WIDTH-1:0];
   assign w_unused_hi = ^w_data_ext[MAX_W-1:ACC_WIDTH];
`endif

   // Sweeps (clear and dump) own both RAM ports; the accumulate pipeline is empty then.
   always_comb begin
      w_we    = r_s1_valid;
      w_waddr = r_s1_addr;
      w_wdata = w_sum;
      w_raddr = i_in_addr;
      if (w_sweep) begin
         w_we    = 1'b1;
         w_waddr = r_cnt;
         w_wdata = '0;
         w_raddr = r_cnt;
      end
   end

   grid_acc_ram #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
   ) u_ram (
      .i_clk  (i_clk),
      .i_we   (w_we),
      .i_waddr(w_waddr),
      .i_wdata(w_wdata),
      .i_raddr(w_raddr),
      .o_rdata(w_rd_data)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1_valid <= 1'b0;
         r_wr_valid <= 1'b0;
      end else begin
         r_s1_valid <= w_accept;
         r_wr_valid <= r_s1_valid;
      end
      if (w_accept) begin
         r_s1_addr <= i_in_addr;
         r_s1_data <= i_in_data;
      end
      r_wr_addr <= r_s1_addr;
      r_wr_data <= w_sum;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= StClear;
         r_cnt    <= '0;
         r_issued <= 1'b0;
         o_busy   <= 1'b1;
      end else begin
         unique case (r_state)
            StClear: begin
               if (r_cnt == LAST_ADDR) begin
                  r_state <= StAccum;
                  o_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + ADDR_WIDTH'(1);
               end
            end
            StAccum: begin
               if (i_dump_req) begin
                  r_state <= StDrain;
                  o_busy  <= 1'b1;
               end
            end
            StDrain: begin
               if (w_dump_start) begin
                  r_state  <= StDump;
                  r_cnt    <= '0;
                  r_issued <= 1'b0;
               end
            end
            StDump: begin
               if (!r_issued) begin
                  if (r_cnt == LAST_ADDR) begin
                     r_issued <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + ADDR_WIDTH'(1);
                  end
               end
               // Stay busy until the last word has left the output register.
               if (o_dump_done) begin
                  r_state <= StAccum;
                  o_busy  <= 1'b0;
               end
            end
            default: r_state <= StClear;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_valid  <= 1'b0;
         o_out_valid <= 1'b0;
         o_out_addr  <= '0;
         o_out_data  <= '0;
         o_dump_done <= 1'b0;
      end else begin
         r_rd_valid  <= w_dump_rd;
         o_out_valid <= r_rd_valid;
         o_dump_done <= r_rd_valid && (r_rd_addr == LAST_ADDR);
         if (r_rd_valid) begin
            o_out_addr <= r_rd_addr;
            o_out_data <= w_rd_data;
         end
      end
      r_rd_addr <= r_cnt;
   end

endmodule
